min_sec_counter: RTL

//   Seconds/minutes timekeeper for the digital clock; sits directly upstream of the hour counter.

---
 rtl/clock_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/min_sec_counter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the seconds/minutes timekeeper.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_MIN  = 2'd1,
        SET_HOUR = 2'd2
    } set_mode_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
        return (value == max) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ cycles while enabled.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic resetN,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = en && (count_q == LAST);

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/min_sec_counter.sv
// Seconds/minutes counter with set mode; emits a registered carry pulse that clocks the hour counter.
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] OutSec,
    output logic [5:0] OutMin,
    output logic       CarryOutHour,
    output logic [1:0] SetMode
);

    set_mode_t  state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic       carry_q, carry_d;
    logic       mode_btn_q, inc_btn_q;

    logic mode_press;
    logic inc_press;
    logic carry_req;
    logic tick;
    logic run_en;

    assign mode_press = mode_btn & ~mode_btn_q;
    // A mode press in the same cycle swallows any inc press.
    assign inc_press  = inc_btn & ~inc_btn_q & ~mode_press;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .resetN (resetN),
        .en     (run_en),
        .clr    (mode_press),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            unique case (state_q)
                RUN:      state_d = SET_MIN;
                SET_MIN:  state_d = SET_HOUR;
                SET_HOUR: state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_comb begin
        SetMode = state_q;
        run_en  = (state_q == RUN);
    end

    always_comb begin
        sec_d     = sec_q;
        min_d     = min_q;
        carry_req = 1'b0;
        if (mode_press) begin
            if (state_q == RUN) begin
                sec_d = 6'd0;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (tick) begin
                        if (sec_q == SEC_MAX) begin
                            sec_d = 6'd0;
                            if (min_q == MIN_MAX) begin
                                min_d     = 6'd0;
                                carry_req = 1'b1;
                            end else begin
                                min_d = min_q + 6'd1;
                            end
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end
                end
                SET_MIN: begin
                    if (inc_press) begin
                        min_d = wrap_inc(min_q, MIN_MAX);
                    end
                end
                SET_HOUR: begin
                    if (inc_press) begin
                        carry_req = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Guarantees a low cycle between any two carry pulses.
        carry_d = carry_req & ~carry_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            carry_q    <= 1'b0;
            mode_btn_q <= 1'b0;
            inc_btn_q  <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            carry_q    <= carry_d;
            mode_btn_q <= mode_btn;
            inc_btn_q  <= inc_btn;
        end
    end

    assign OutSec       = sec_q;
    assign OutMin       = min_q;
    assign CarryOutHour = carry_q;

endmodule
